snitch_icache_data_fill: RTL and testbench

// Refill-side write stage directly upstream of the icache data array.
// - Accepts a fill command (target set + line index).
// - Collects FILL_DW-wide refill beats into one LINE_WIDTH line.
// - Issues a single full-line write to the data SRAMs, held until the array arbiter grants it.
// - Reports completion, or error, to the lookup/refill controller.

---
 rtl/snitch_icache_data_fill.sv | 112 +++++++++++
 tb/tb_snitch_icache_data_fill.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_data_fill.sv
// Refill write stage for the icache data array: gathers refill beats into one line,
// writes it to the selected set once the array arbiter grants, then reports completion.
module snitch_icache_data_fill #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned FILL_DW     = 64,
  parameter int unsigned SET_COUNT   = 4,
  parameter int unsigned COUNT_ALIGN = 7,
  localparam int unsigned SET_W      = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [SET_W-1:0]       req_set_i,
  input  logic [COUNT_ALIGN-1:0] req_addr_i,
  input  logic                   beat_valid_i,
  output logic                   beat_ready_o,
  input  logic [FILL_DW-1:0]     beat_data_i,
  input  logic                   beat_error_i,
  output logic [SET_COUNT-1:0]   ram_enable_o,
  output logic                   ram_write_o,
  output logic [COUNT_ALIGN-1:0] ram_addr_o,
  output logic [LINE_WIDTH-1:0]  ram_wdata_o,
  input  logic                   ram_gnt_i,
  output logic                   done_valid_o,
  output logic                   done_error_o,
  output logic [SET_W-1:0]       done_set_o,
  output logic [COUNT_ALIGN-1:0] done_addr_o,
  output logic [1:0]             state_o
);

  localparam int unsigned BEATS = LINE_WIDTH / FILL_DW;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   err;
  logic [SET_W-1:0]       set_q;
  logic [COUNT_ALIGN-1:0] addr_q;
  logic [LINE_WIDTH-1:0]  line_q;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready depends only on the registered state, never on the matching valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      err    <= 1'b0;
      set_q  <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            set_q  <= req_set_i;
            addr_q <= req_addr_i;
            cnt    <= '0;
            err    <= 1'b0;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_valid_i) begin
            for (int b = 0; b < int'(BEATS); b++) begin
              if (cnt == CNT_W'(b)) line_q[b*FILL_DW +: FILL_DW] <= beat_data_i;
            end
            err <= err | beat_error_i;
            cnt <= cnt + 1'b1;
            // A poisoned line skips the array write and is reported as an error.
            if (cnt == CNT_W'(BEATS - 1)) state <= (err | beat_error_i) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (ram_gnt_i) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic in_write;
  logic in_done;
  assign in_write = (state == WRITE);
  assign in_done  = (state == DONE);

  assign req_ready_o  = (state == IDLE);
  assign beat_ready_o = (state == COLLECT);

  assign ram_enable_o = in_write ? (SET_COUNT'(1) << set_q) : '0;
  assign ram_write_o  = in_write;
  assign ram_addr_o   = in_write ? addr_q : '0;
  assign ram_wdata_o  = in_write ? line_q : '0;

  assign done_valid_o = in_done;
  assign done_error_o = in_done & err;
  assign done_set_o   = in_done ? set_q : '0;
  assign done_addr_o  = in_done ? addr_q : '0;

  assign state_o = state;

endmodule

// File: tb/tb_snitch_icache_data_fill.sv
// Directed and randomized bench for snitch_icache_data_fill: a 4-beat instance and a
// single-beat instance, checked against expected lines and completions built from beats.
module tb_snitch_icache_data_fill;

  logic clk;
  logic rst_n;

  // 4-beat instance
  logic         req_valid, req_ready;
  logic [1:0]   req_set;
  logic [6:0]   req_addr;
  logic         beat_valid, beat_ready, beat_error;
  logic [63:0]  beat_data;
  logic [3:0]   ram_enable;
  logic         ram_write, ram_gnt;
  logic [6:0]   ram_addr;
  logic [255:0] ram_wdata;
  logic         done_valid, done_error;
  logic [1:0]   done_set;
  logic [6:0]   done_addr;
  logic [1:0]   state0;

  // single-beat instance
  logic         req_valid1, req_ready1;
  logic [1:0]   req_set1;
  logic [6:0]   req_addr1;
  logic         beat_valid1, beat_ready1, beat_error1;
  logic [63:0]  beat_data1;
  logic [3:0]   ram_enable1;
  logic         ram_write1, ram_gnt1;
  logic [6:0]   ram_addr1;
  logic [63:0]  ram_wdata1;
  logic         done_valid1, done_error1;
  logic [1:0]   done_set1;
  logic [6:0]   done_addr1;
  logic [1:0]   state1;

  int checks = 0;
  int errors = 0;

  int wr_cnt = 0, done_cnt = 0, en_cycles = 0;
  logic [3:0]   wr_en;
  logic [6:0]   wr_addr;
  logic [255:0] wr_data;

  snitch_icache_data_fill u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set), .req_addr_i(req_addr),
    .beat_valid_i(beat_valid), .beat_ready_o(beat_ready), .beat_data_i(beat_data),
    .beat_error_i(beat_error),
    .ram_enable_o(ram_enable), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_gnt_i(ram_gnt),
    .done_valid_o(done_valid), .done_error_o(done_error), .done_set_o(done_set),
    .done_addr_o(done_addr), .state_o(state0)
  );

  snitch_icache_data_fill #(.LINE_WIDTH(64), .FILL_DW(64), .SET_COUNT(4), .COUNT_ALIGN(7)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_set_i(req_set1),
    .req_addr_i(req_addr1),
    .beat_valid_i(beat_valid1), .beat_ready_o(beat_ready1), .beat_data_i(beat_data1),
    .beat_error_i(beat_error1),
    .ram_enable_o(ram_enable1), .ram_write_o(ram_write1), .ram_addr_o(ram_addr1),
    .ram_wdata_o(ram_wdata1), .ram_gnt_i(ram_gnt1),
    .done_valid_o(done_valid1), .done_error_o(done_error1), .done_set_o(done_set1),
    .done_addr_o(done_addr1), .state_o(state1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  // observed array writes and completions of the 4-beat instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_enable != 4'd0) en_cycles <= en_cycles + 1;
      if (ram_write && ram_gnt) begin
        wr_cnt  <= wr_cnt + 1;
        wr_en   <= ram_enable;
        wr_addr <= ram_addr;
        wr_data <= ram_wdata;
      end
      if (done_valid) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_beat_ready"}, beat_ready, 0);
    chk({tag, "_ram_enable"}, ram_enable, 0);
    chk({tag, "_ram_write"}, ram_write, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_done_error"}, done_error, 0);
    chk({tag, "_done_set"}, done_set, 0);
    chk({tag, "_done_addr"}, done_addr, 0);
  endtask

  // One fill on the 4-beat instance. err_beat < 0 means a clean line.
  task automatic do_fill(input logic [1:0] s, input logic [6:0] a, input bit fixed_data,
                         input int err_beat, input int gap, input int stall, input bit rst_mid);
    logic [255:0] line_exp;
    logic [63:0]  b;
    bit           err_exp;
    int           wr0, dn0, en0, t;
    wr0 = wr_cnt; dn0 = done_cnt; en0 = en_cycles;
    line_exp = '0; err_exp = 0;

    t = 0;
    while (!req_ready && t < 50) begin step(); t++; end
    chk("cmd_req_ready", req_ready, 1);
    req_valid = 1; req_set = s; req_addr = a; ram_gnt = (stall == 0);
    step();
    req_set = ~s; req_addr = ~a;

    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        beat_valid = 0;
        chk("gap_req_ready", req_ready, 0);
        step();
      end
      b = fixed_data ? {8{8'(8'h11 * (i + 1))}} : {$urandom, $urandom};
      beat_valid = 1; beat_data = b; beat_error = (i == err_beat);
      t = 0;
      while (!beat_ready && t < 20) begin step(); t++; end
      chk("beat_ready", beat_ready, 1);
      chk("busy_req_ready", req_ready, 0);
      line_exp[i*64 +: 64] = b;
      if (i == err_beat) err_exp = 1;
      step();
      if (rst_mid && i == 1) begin
        #2 rst_n = 0;
        #1 chk_reset_outputs("mid_reset");
        req_valid = 0; beat_valid = 0; beat_error = 0; ram_gnt = 1;
        @(negedge clk);
        rst_n = 1;
        step();
        chk("mid_reset_no_write", wr_cnt - wr0, 0);
        chk("mid_reset_no_done", done_cnt - dn0, 0);
        return;
      end
    end
    beat_valid = 1; beat_data = '1; beat_error = 1; req_valid = 0;

    if (!err_exp) begin
      for (int k = 0; k <= stall; k++) begin
        ram_gnt = (k == stall);
        chk("wr_write", ram_write, 1);
        chk("wr_enable", ram_enable, 4'b0001 << s);
        chk("wr_addr", ram_addr, a);
        chk("wr_wdata", ram_wdata, line_exp);
        chk("wr_done_quiet", done_valid, 0);
        chk("wr_beat_ready", beat_ready, 0);
        chk("wr_req_ready", req_ready, 0);
        step();
      end
    end
    chk("done_valid", done_valid, 1);
    chk("done_error", done_error, err_exp);
    chk("done_set", done_set, s);
    chk("done_addr", done_addr, a);
    chk("done_enable", ram_enable, 0);
    chk("done_req_ready", req_ready, 0);
    chk("done_beat_ready", beat_ready, 0);
    step();
    chk("post_done_valid", done_valid, 0);
    chk("post_done_fields", {done_error, done_set, done_addr}, 0);
    chk("post_req_ready", req_ready, 1);
    chk("write_count", wr_cnt - wr0, err_exp ? 0 : 1);
    chk("done_count", done_cnt - dn0, 1);
    if (err_exp) begin
      chk("err_no_enable", en_cycles - en0, 0);
    end else begin
      chk("enable_cycles", en_cycles - en0, stall + 1);
      chk("wr_seen_data", wr_data, line_exp);
      chk("wr_seen_enable", wr_en, 4'b0001 << s);
      chk("wr_seen_addr", wr_addr, a);
    end
    beat_valid = 0; beat_error = 0; ram_gnt = 1;
  endtask

  initial begin
    logic [1:0]  s1;
    logic [6:0]  a1;
    logic [63:0] d1;
    rst_n = 0;
    req_valid = 0; req_set = 0; req_addr = 0;
    beat_valid = 0; beat_data = 0; beat_error = 0; ram_gnt = 0;
    req_valid1 = 0; req_set1 = 0; req_addr1 = 0;
    beat_valid1 = 0; beat_data1 = 0; beat_error1 = 0; ram_gnt1 = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    step();

    do_fill(2'd2, 7'h15, 1, -1, 0, 0, 0);
    do_fill(2'd2, 7'h15, 1, -1, 0, 5, 0);
    do_fill(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 0, 2, 0, 0, 0);
    do_fill(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 0, -1, 2, 1, 0);
    do_fill(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 0, -1, 0, 0, 1);
    do_fill(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 0, -1, 0, 0, 0);
    for (int n = 0; n < 10; n++) begin
      do_fill(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
    end

    // single-beat instance, commands and beats offered back-to-back
    s1 = 2'($urandom_range(0, 3)); a1 = 7'($urandom_range(0, 127));
    req_valid1 = 1; req_set1 = s1; req_addr1 = a1;
    beat_valid1 = 1; beat_data1 = {$urandom, $urandom}; beat_error1 = 1; ram_gnt1 = 1;
    for (int n = 0; n < 6; n++) begin
      chk("b1_req_ready", req_ready1, 1);
      chk("b1_idle_beat_ready", beat_ready1, 0);
      chk("b1_idle_write", ram_write1, 0);
      step();
      d1 = {$urandom, $urandom};
      beat_data1 = d1; beat_error1 = 0;
      chk("b1_beat_ready", beat_ready1, 1);
      chk("b1_busy_req_ready", req_ready1, 0);
      step();
      beat_data1 = {$urandom, $urandom}; beat_error1 = 1;
      chk("b1_write", ram_write1, 1);
      chk("b1_enable", ram_enable1, 4'b0001 << s1);
      chk("b1_addr", ram_addr1, a1);
      chk("b1_wdata", ram_wdata1, d1);
      chk("b1_write_done_quiet", done_valid1, 0);
      step();
      chk("b1_done_valid", done_valid1, 1);
      chk("b1_done_error", done_error1, 0);
      chk("b1_done_set", done_set1, s1);
      chk("b1_done_addr", done_addr1, a1);
      chk("b1_done_req_ready", req_ready1, 0);
      chk("b1_done_enable", ram_enable1, 0);
      s1 = 2'($urandom_range(0, 3)); a1 = 7'($urandom_range(0, 127));
      req_set1 = s1; req_addr1 = a1;
      step();
    end
    req_valid1 = 0; beat_valid1 = 0;
    step();
    chk("b1_final_idle", req_ready1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
